// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a 2-entry prefetch queue.
// Optional FETCH_FLUSH_CNT_EN adds a saturating flush_count output counting redirect cycles.
//
// state   | meaning
// S_RUN   | normal fetch; responses are pushed into the queue
// S_FLUSH | redirect hit a pending request; hold it and discard its response
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] instructionOut,
    output logic [15:0] adder1Out,
    output logic        valid_out
`ifdef FETCH_FLUSH_CNT_EN
    ,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    localparam logic [1:0] QD = 2'(QDEPTH);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [15:0] addr_q, addr_d;
    logic        en_q;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] e0_instr_q, e0_instr_d, e0_next_q, e0_next_d;
    logic [15:0] e1_instr_q, e1_instr_d, e1_next_q, e1_next_d;
    logic        push, pop;

    // Held requests present the latched address; otherwise the fetch PC is offered.
    assign imem_req  = req_q | (en_q & (state_q == S_RUN) & (cnt_q < QD));
    assign imem_addr = req_q ? addr_q : pc_q;

    assign valid_out      = (cnt_q != 2'd0);
    assign instructionOut = valid_out ? e0_instr_q : 16'h0000;
    assign adder1Out      = valid_out ? e0_next_q  : 16'h0000;

    assign pop  = valid_out & ~stall;
    assign push = imem_req & imem_ack & (state_q == S_RUN);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        e0_instr_d = e0_instr_q;
        e0_next_d  = e0_next_q;
        e1_instr_d = e1_instr_q;
        e1_next_d  = e1_next_q;

        if (branch_taken) begin
            pc_d  = branch_target;
            cnt_d = 2'd0;
            if (imem_req && !imem_ack) begin
                state_d = S_FLUSH;
                req_d   = 1'b1;
                addr_d  = imem_addr;
            end else begin
                state_d = S_RUN;
                req_d   = 1'b0;
            end
        end else if (state_q == S_FLUSH) begin
            if (imem_ack) begin
                state_d = S_RUN;
                req_d   = 1'b0;
            end
        end else begin
            if (push) begin
                req_d = 1'b0;
                pc_d  = imem_addr + 16'd1;
            end else if (imem_req) begin
                req_d  = 1'b1;
                addr_d = imem_addr;
            end

            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        e0_instr_d = imem_rdata;
                        e0_next_d  = imem_addr + 16'd1;
                    end else begin
                        e1_instr_d = imem_rdata;
                        e1_next_d  = imem_addr + 16'd1;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_instr_d = e1_instr_q;
                    e0_next_d  = e1_next_q;
                    cnt_d      = cnt_q - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new word lands behind whatever remains.
                    if (cnt_q == 2'd1) begin
                        e0_instr_d = imem_rdata;
                        e0_next_d  = imem_addr + 16'd1;
                    end else begin
                        e0_instr_d = e1_instr_q;
                        e0_next_d  = e1_next_q;
                        e1_instr_d = imem_rdata;
                        e1_next_d  = imem_addr + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            en_q       <= 1'b0;
            cnt_q      <= 2'd0;
            e0_instr_q <= 16'h0000;
            e0_next_q  <= 16'h0000;
            e1_instr_q <= 16'h0000;
            e1_next_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            en_q       <= 1'b1;
            cnt_q      <= cnt_d;
            e0_instr_q <= e0_instr_d;
            e0_next_q  <= e0_next_d;
            e1_instr_q <= e1_instr_d;
            e1_next_q  <= e1_next_d;
        end
    end

`ifdef FETCH_FLUSH_CNT_EN
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_cnt_q <= 16'h0000;
        end else if (branch_taken && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign flush_count = flush_cnt_q;
`endif

endmodule
